// File: rtl/alu_seq_pkg.sv
// Shared types and field constants for the 4-bit computer control unit.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_MOV  = 4'h2,
    OP_LDR  = 4'h3,
    OP_SETS = 4'h4,
    OP_SETM = 4'h5,
    OP_EXR  = 4'h6,
    OP_EXI  = 4'h7,
    OP_JMP  = 4'h8,
    OP_JZ   = 4'h9,
    OP_JEQ  = 4'hA,
    OP_OUT  = 4'hB,
    OP_HLT  = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    OUT_WAIT,
    HALT
  } state_e;

  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;
  localparam int OPR_MSB = 3;
  localparam int OPR_LSB = 0;

  localparam logic CN_NOCARRY = 1'b1;

endpackage

// File: rtl/seq_regfile.sv
// General register file: one write port, two asynchronous read ports.
module seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int NREG = 4,
  parameter int DW   = 4,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] regs [NREG];

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      logic [DW-1:0] r_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_reg <= '0;
        end else if (we && (waddr == AW'(gi))) begin
          r_reg <= wdata;
        end
      end

      assign regs[gi] = r_reg;
    end
  endgenerate

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute sequencer driving a 74181-style ALU, with an
// accumulator, small register file and a ready/valid output port.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int PC_W = 4,
  parameter int NREG = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [PC_W-1:0] instr_addr,
  input  logic [7:0]      instr_data,
  output logic [3:0]      alu_sel,
  output logic            alu_m,
  output logic            alu_cn,
  output logic [3:0]      alu_a,
  output logic [3:0]      alu_b,
  input  logic [3:0]      alu_f,
  input  logic            alu_abflag,
  output logic [3:0]      acc,
  output logic            zero_flag,
  output logic            eq_flag,
  output logic [3:0]      out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic            halted
);

  localparam int RA_W = $clog2(NREG);

  state_e          state_reg, state_next;
  logic [PC_W-1:0] pc_reg;
  logic [7:0]      ir_reg;
  logic [3:0]      acc_reg, b_reg, sel_reg, out_data_reg;
  logic            m_reg, cn_reg, zero_reg, eq_reg, out_valid_reg;

  logic [3:0]      dec_opc, ex_opc, ex_opr;
  logic [PC_W-1:0] jmp_target;
  logic [3:0]      rf_rdata_a, rf_rdata_b;
  logic            rf_we;

  assign dec_opc    = instr_data[OPC_MSB:OPC_LSB];
  assign ex_opc     = ir_reg[OPC_MSB:OPC_LSB];
  assign ex_opr     = ir_reg[OPR_MSB:OPR_LSB];
  assign jmp_target = PC_W'(ex_opr);
  assign rf_we      = (state_reg == EXEC) && (ex_opc == OP_MOV);

  seq_regfile #(
    .NREG (NREG),
    .DW   (4)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (ir_reg[RA_W-1:0]),
    .wdata   (acc_reg),
    .raddr_a (instr_data[RA_W-1:0]),
    .rdata_a (rf_rdata_a),
    .raddr_b (ir_reg[RA_W-1:0]),
    .rdata_b (rf_rdata_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, HALT: if (start) state_next = FETCH;
      FETCH:      state_next = DECODE;
      DECODE:     state_next = EXEC;
      EXEC: begin
        if (ex_opc == OP_OUT)      state_next = OUT_WAIT;
        else if (ex_opc == OP_HLT) state_next = HALT;
        else                       state_next = FETCH;
      end
      OUT_WAIT:   if (out_ready) state_next = FETCH;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_reg != IDLE) && (state_reg != HALT);
    halted = (state_reg == HALT);
  end

  // The DECODE increment happens first, so a taken jump in EXEC simply overwrites it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg        <= '0;
      ir_reg        <= '0;
      acc_reg       <= '0;
      b_reg         <= '0;
      sel_reg       <= '0;
      m_reg         <= 1'b0;
      cn_reg        <= CN_NOCARRY;
      zero_reg      <= 1'b0;
      eq_reg        <= 1'b0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, HALT: if (start) pc_reg <= '0;
        DECODE: begin
          ir_reg <= instr_data;
          pc_reg <= pc_reg + PC_W'(1);
          if (dec_opc == OP_EXR)      b_reg <= rf_rdata_a;
          else if (dec_opc == OP_EXI) b_reg <= instr_data[OPR_MSB:OPR_LSB];
        end
        EXEC: begin
          case (ex_opc)
            OP_LDI: begin
              acc_reg  <= ex_opr;
              zero_reg <= (ex_opr == 4'd0);
            end
            OP_LDR: begin
              acc_reg  <= rf_rdata_b;
              zero_reg <= (rf_rdata_b == 4'd0);
            end
            OP_SETS: sel_reg <= ex_opr;
            OP_SETM: begin
              m_reg  <= ex_opr[1];
              cn_reg <= ex_opr[0];
            end
            OP_EXR, OP_EXI: begin
              acc_reg  <= alu_f;
              zero_reg <= (alu_f == 4'd0);
              eq_reg   <= alu_abflag;
            end
            OP_JMP: pc_reg <= jmp_target;
            OP_JZ:  if (zero_reg) pc_reg <= jmp_target;
            OP_JEQ: if (eq_reg) pc_reg <= jmp_target;
            OP_OUT: begin
              out_data_reg  <= acc_reg;
              out_valid_reg <= 1'b1;
            end
            default: ;
          endcase
        end
        OUT_WAIT: if (out_ready) out_valid_reg <= 1'b0;
        default: ;
      endcase
    end
  end

  assign instr_addr = pc_reg;
  assign alu_sel    = sel_reg;
  assign alu_m      = m_reg;
  assign alu_cn     = cn_reg;
  assign alu_a      = acc_reg;
  assign alu_b      = b_reg;
  assign acc        = acc_reg;
  assign zero_flag  = zero_reg;
  assign eq_flag    = eq_reg;
  assign out_data   = out_data_reg;
  assign out_valid  = out_valid_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: synchronous ROM, 74181 model and an output scoreboard.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, start, out_ready;
  logic [3:0] instr_addr;
  logic [7:0] instr_data;
  logic [3:0] alu_sel, alu_a, alu_b, alu_f, acc, out_data;
  logic       alu_m, alu_cn, alu_abflag, zero_flag, eq_flag, out_valid, busy, halted;

  int n_vec = 0;
  int n_bad = 0;
  int n_hs = 0;
  int n_valid_cyc = 0;
  logic [3:0] sb_q [$];
  int addr_log [$];
  bit log_en = 0;

  logic [7:0] rom [16];
  logic [7:0] prog1 [8] = '{8'h49, 8'h51, 8'h15, 8'h73, 8'hB0, 8'hF0, 8'h00, 8'h00};
  logic [7:0] prog2 [8] = '{8'h52, 8'h46, 8'h1A, 8'h7A, 8'h96, 8'hF0, 8'hB0, 8'hF0};
  logic [7:0] prog4 [8] = '{8'h13, 8'h22, 8'h10, 8'h32, 8'hB0, 8'hF0, 8'h00, 8'h00};

  always #5 clk = ~clk;

  alu_sequencer #(.PC_W(4), .NREG(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .instr_addr (instr_addr),
    .instr_data (instr_data),
    .alu_sel    (alu_sel),
    .alu_m      (alu_m),
    .alu_cn     (alu_cn),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_f      (alu_f),
    .alu_abflag (alu_abflag),
    .acc        (acc),
    .zero_flag  (zero_flag),
    .eq_flag    (eq_flag),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .halted     (halted)
  );

  // Active-high 74181 function table; cn is active-low carry-in.
  function automatic logic [3:0] alu181(input logic [3:0] s, input logic m, input logic cn,
                                        input logic [3:0] a, input logic [3:0] b);
    logic [3:0] ci;
    ci = cn ? 4'd0 : 4'd1;
    if (m) begin
      case (s)
        4'h0: return ~a;        4'h1: return ~(a | b);
        4'h2: return ~a & b;    4'h3: return 4'h0;
        4'h4: return ~(a & b);  4'h5: return ~b;
        4'h6: return a ^ b;     4'h7: return a & ~b;
        4'h8: return ~a | b;    4'h9: return ~(a ^ b);
        4'hA: return b;         4'hB: return a & b;
        4'hC: return 4'hF;      4'hD: return a | ~b;
        4'hE: return a | b;     default: return a;
      endcase
    end
    case (s)
      4'h0: return a + ci;                    4'h1: return (a | b) + ci;
      4'h2: return (a | ~b) + ci;             4'h3: return 4'hF + ci;
      4'h4: return a + (a & ~b) + ci;         4'h5: return (a | b) + (a & ~b) + ci;
      4'h6: return a + ~b + ci;               4'h7: return (a & ~b) + 4'hF + ci;
      4'h8: return a + (a & b) + ci;          4'h9: return a + b + ci;
      4'hA: return (a | ~b) + (a & b) + ci;   4'hB: return (a & b) + 4'hF + ci;
      4'hC: return a + a + ci;                4'hD: return (a | b) + a + ci;
      4'hE: return (a | ~b) + a + ci;         default: return a + 4'hF + ci;
    endcase
  endfunction

  assign alu_f      = alu181(alu_sel, alu_m, alu_cn, alu_a, alu_b);
  assign alu_abflag = (alu_f == 4'hF);

  always @(posedge clk) instr_data <= rom[instr_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: pop on every accepted output beat.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      n_valid_cyc++;
      if (out_ready) begin
        n_hs++;
        $display("out beat: out_data=%0h", out_data);
        if (sb_q.size() == 0) check("sb_unexpected_beat", {28'd0, out_data}, 32'hFFFF_FFFF);
        else check("out_data", out_data, sb_q.pop_front());
      end
    end
    if (log_en && busy && (addr_log.size() == 0 || addr_log[$] != int'(instr_addr)))
      addr_log.push_back(int'(instr_addr));
  end

  task automatic load_prog(input logic [7:0] p [8]);
    for (int i = 0; i < 16; i++) rom[i] = (i < 8) ? p[i] : 8'h00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_prog(input int budget);
    bit done;
    done = 0;
    n_hs = 0;
    n_valid_cyc = 0;
    pulse_start();
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (halted) done = 1;
    end
    check("halted", halted, 1);
  endtask

  task automatic wait_valid(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("out_valid_seen", out_valid, 1);
  endtask

  int cnt15, cnt_bad;
  bit found;

  initial begin
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
    load_prog(prog1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_acc", acc, 0);
    check("rst_cn", alu_cn, 1);
    check("rst_m_sel", {alu_m, alu_sel, alu_b}, 0);
    check("rst_flags", {zero_flag, eq_flag, out_valid, busy, halted}, 0);
    check("rst_addr", instr_addr, 0);

    // ADD 5+3 then output
    sb_q.push_back(4'h8);
    run_prog(100);
    check("p1_acc", acc, 8);
    check("p1_zero", zero_flag, 0);
    check("p1_valid_cycles", n_valid_cyc, 1);
    check("p1_beats", n_hs, 1);

    // XOR to zero, JZ taken to the OUT at address 6
    load_prog(prog2);
    sb_q.push_back(4'h0);
    run_prog(100);
    check("p2_acc", acc, 0);
    check("p2_zero", zero_flag, 1);
    check("p2_eq", eq_flag, 0);
    check("p2_beats", n_hs, 1);
    check("p2_end_pc", instr_addr, 8);

    // Backpressure on the output port
    load_prog(prog1);
    out_ready = 1'b0;
    sb_q.push_back(4'h8);
    n_hs = 0; n_valid_cyc = 0;
    pulse_start();
    wait_valid(100);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_busy", busy, 1);
      check("bp_data", out_data, 8);
      @(posedge clk);
      #1 if (i == 2) out_ready = 1'b1;
      @(negedge clk);
    end
    check("bp_valid_4th", out_valid, 1);
    @(negedge clk);
    check("bp_drop", out_valid, 0);
    check("bp_busy_after", busy, 1);
    check("bp_fetch_addr", instr_addr, 5);
    for (int i = 0; i < 20 && !halted; i++) @(negedge clk);
    check("bp_halted", halted, 1);
    check("bp_valid_cycles", n_valid_cyc, 4);

    // Register round-trip and address sequence
    load_prog(prog4);
    sb_q.push_back(4'h3);
    addr_log.delete();
    log_en = 1;
    run_prog(100);
    log_en = 0;
    check("p4_acc", acc, 3);
    check("p4_addr_count", addr_log.size(), 7);
    for (int i = 0; i < 7; i++)
      check("p4_addr_seq", (i < addr_log.size()) ? addr_log[i] : -1, i);

    // PC wraparound through 16 NOPs
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    addr_log.delete();
    log_en = 1;
    pulse_start();
    repeat (60) @(negedge clk);
    log_en = 0;
    check("wrap_busy", {busy, halted}, 2'b10);
    check("wrap_at15", (addr_log.size() > 16) ? addr_log[15] : -1, 15);
    check("wrap_to0", (addr_log.size() > 16) ? addr_log[16] : -1, 0);
    do_reset();

    // Tight loop: JMP 15 at address 15
    rom[15] = 8'h8F;
    pulse_start();
    repeat (60) @(negedge clk);
    cnt15 = 0; cnt_bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (instr_addr == 4'd15) cnt15++;
      else if (instr_addr != 4'd0) cnt_bad++;
    end
    check("loop_addr15", cnt15, 20);
    check("loop_other", cnt_bad, 0);
    do_reset();

    // Reset during EXEC of EXI
    load_prog(prog1);
    pulse_start();
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (instr_addr == 4'd4 && alu_b == 4'd3) found = 1;
    end
    check("exi_exec_seen", {instr_addr, alu_b}, 8'h43);
    rst_n = 1'b0;
    #1;
    check("mid_rst_acc", acc, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cn", alu_cn, 1);
    check("mid_rst_valid", out_valid, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset while stalled in OUT_WAIT drops out_valid at once
    out_ready = 1'b0;
    pulse_start();
    wait_valid(100);
    rst_n = 1'b0;
    #1;
    check("ow_rst_valid", out_valid, 0);
    check("ow_rst_busy", busy, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;

    // Re-run matches the first run
    sb_q.push_back(4'h8);
    run_prog(100);
    check("rerun_acc", acc, 8);
    check("rerun_beats", n_hs, 1);
    check("rerun_end_pc", instr_addr, 6);

    check("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
